// File: rtl/counter_monitor.sv
// Receive-side checker for an up/down counter stream: classifies each sampled
// step as hold/up/down/bad (mod 2^WIDTH), locks on a consistent run, and counts violations.
module counter_monitor #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 dir,
  output logic                 moving,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_value
);

  typedef enum logic [1:0] {S_EMPTY, S_SYNC, S_LOCKED} state_e;

  localparam int RUN_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 dir_q, dir_d;
  logic                 moving_q, moving_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     last_q, last_d;

  logic [WIDTH-1:0] up_val, down_val;
  logic             is_hold, is_up, is_down, is_bad;

  assign up_val   = last_q + WIDTH'(1);
  assign down_val = last_q - WIDTH'(1);
  assign is_hold  = (count_in == last_q);
  assign is_up    = (count_in == up_val);
  assign is_down  = (count_in == down_val);
  assign is_bad   = !(is_hold || is_up || is_down);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    locked_d = locked_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    last_d   = last_q;

    if (clear_err) begin
      err_d = 1'b0;
      cnt_d = '0;
    end

    if (sample_valid) begin
      last_d = count_in;
      case (state_q)
        S_EMPTY: begin
          run_d   = '0;
          state_d = S_SYNC;
        end
        S_SYNC: begin
          if (is_bad) begin
            run_d = '0;
          end else begin
            run_d    = run_q + 1'b1;
            moving_d = !is_hold;
            if (is_up)   dir_d = 1'b1;
            if (is_down) dir_d = 1'b0;
            if (run_d >= LOCK_RUN) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (is_bad) begin
            // A violation outranks a same-cycle clear: the count restarts at one.
            err_d    = 1'b1;
            cnt_d    = sat_inc(clear_err ? '0 : cnt_q);
            locked_d = 1'b0;
            moving_d = 1'b0;
            run_d    = '0;
            state_d  = S_SYNC;
          end else begin
            moving_d = !is_hold;
            if (is_up)   dir_d = 1'b1;
            if (is_down) dir_d = 1'b0;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      run_q    <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      moving_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign locked     = locked_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign err        = err_q;
  assign err_count  = cnt_q;
  assign last_value = last_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: an 8-bit error counter instance plus a
// 2-bit one sharing the same stimulus to observe saturation.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] count_in = 8'h00;
  logic       clear_err = 1'b0;

  logic       locked, dir, moving, err;
  logic [7:0] err_count, last_value;
  logic       locked2, dir2, moving2, err2;
  logic [1:0] err_count2;
  logic [7:0] last_value2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(8), .ERR_CNT_W(8), .LOCK_LEN(2)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .count_in(count_in),
    .clear_err(clear_err), .locked(locked), .dir(dir), .moving(moving),
    .err(err), .err_count(err_count), .last_value(last_value)
  );

  counter_monitor #(.WIDTH(8), .ERR_CNT_W(2), .LOCK_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .count_in(count_in),
    .clear_err(clear_err), .locked(locked2), .dir(dir2), .moving(moving2),
    .err(err2), .err_count(err_count2), .last_value(last_value2)
  );

  task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic c);
    rst = r; sample_valid = v; count_in = d; clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] cur;

    // reset with garbage sample present
    tick(1, 1, 8'h33, 0);
    tick(1, 1, 8'h33, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dir", dir, 0);
    chk("rst_moving", moving, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_last", last_value, 0);
    chk("rst_errcnt2", err_count2, 0);

    // up lock
    tick(0, 1, 8'h00, 0);
    tick(0, 1, 8'h01, 0);
    chk("up_notyet", locked, 0);
    tick(0, 1, 8'h02, 0);
    chk("up_locked", locked, 1);
    chk("up_dir", dir, 1);
    chk("up_moving", moving, 1);
    chk("up_err", err, 0);
    chk("up_last", last_value, 8'h02);

    // wrap both ways, after a reset mid-lock
    tick(1, 0, 8'h00, 0);
    tick(0, 1, 8'hFE, 0);
    chk("rst_midlock_unlocked", locked, 0);
    tick(0, 1, 8'hFF, 0);
    tick(0, 1, 8'h00, 0);
    tick(0, 1, 8'h01, 0);
    chk("wrapup_locked", locked, 1);
    chk("wrapup_dir", dir, 1);
    chk("wrapup_err", err, 0);
    tick(0, 1, 8'h00, 0);
    tick(0, 1, 8'hFF, 0);
    tick(0, 1, 8'hFE, 0);
    chk("wrapdn_dir", dir, 0);
    chk("wrapdn_err", err, 0);
    chk("wrapdn_locked", locked, 1);
    chk("wrapdn_last", last_value, 8'hFE);

    // hold and idle while locked at 0x05
    tick(1, 0, 8'h00, 0);
    tick(0, 1, 8'h03, 0);
    tick(0, 1, 8'h04, 0);
    tick(0, 1, 8'h05, 0);
    chk("hold_pre_locked", locked, 1);
    tick(0, 1, 8'h05, 0);
    tick(0, 1, 8'h05, 0);
    chk("hold_moving", moving, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h99, 0);
    chk("idle_moving", moving, 0);
    chk("idle_dir", dir, 1);
    chk("idle_locked", locked, 1);
    chk("idle_last", last_value, 8'h05);
    chk("idle_err", err, 0);

    // violation and relock
    tick(1, 0, 8'h00, 0);
    tick(0, 1, 8'h0E, 0);
    tick(0, 1, 8'h0F, 0);
    tick(0, 1, 8'h10, 0);
    tick(0, 1, 8'h20, 0);
    chk("viol_err", err, 1);
    chk("viol_errcnt", err_count, 1);
    chk("viol_locked", locked, 0);
    chk("viol_moving", moving, 0);
    chk("viol_dir", dir, 1);
    chk("viol_last", last_value, 8'h20);
    tick(0, 1, 8'h21, 0);
    chk("relock_notyet", locked, 0);
    tick(0, 1, 8'h22, 0);
    chk("relock_locked", locked, 1);
    chk("relock_err", err, 1);
    chk("relock_errcnt", err_count, 1);

    // clear in the same cycle as a violation: error wins, count restarts at 1
    tick(0, 1, 8'h50, 1);
    chk("clrviol_err", err, 1);
    chk("clrviol_errcnt", err_count, 1);
    chk("clrviol_errcnt2", err_count2, 1);
    tick(0, 0, 8'h00, 1);
    chk("clr_err", err, 0);
    chk("clr_errcnt", err_count, 0);
    chk("clr_errcnt2", err_count2, 0);

    // five violations, each after relock
    cur = 8'h50;
    for (int i = 0; i < 5; i++) begin
      cur = cur + 8'h01; tick(0, 1, cur, 0);
      cur = cur + 8'h01; tick(0, 1, cur, 0);
      chk("sat_relock", locked, 1);
      cur = cur + 8'h40; tick(0, 1, cur, 0);
    end
    chk("sat_errcnt8", err_count, 5);
    chk("sat_errcnt2", err_count2, 3);
    chk("sat_err2", err2, 1);
    chk("sat_locked2", locked2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
